ecc_sec_check_encoder: RTL and testbench
========================================

// Module: ecc_sec_check_encoder
// PURPOSE
// - Transmit-side companion of the 32-bit SEC checker/corrector (c499 family).
// - Accepts 32-bit data words on a valid/ready stream and computes the 8 check bits
//   c[7:0] that the corrector expects on its check inputs (N129..N136, with N137=1).
// - Emits data and check together on a 2-stage pipeline, with full backpressure.
// - Provides a single-bit fault-injection hook and a handshake counter for corrector benches.
// PARAMETERS
// - DATA_W  32  data width; 32 is the only legal value, checked by an elaboration assert.
// - CNT_W   16  width of the words_cnt counter.
// PORTS
// - clk        in   1       clock; all state updates on the rising edge.
// - rst_n      in   1       reset, asynchronous assert, active-low.
// - in_valid   in   1       in_data is valid.
// - in_ready   out  1       block accepts a word this cycle.
// - in_data    in   32      d[i] = in_data[i]; d[i] maps to corrector input N(1+4i).
// - chk_en     in   1       sampled with the word; 0 forces the emitted check to 8'h00.
// - inj_en     in   1       sampled with the word; 1 flips one codeword bit.
// - inj_pos    in   6       flipped bit: 0..31 = data bit; 32..39 = check bit pos-32; >=40 = none.
// - out_valid  out  1       out_data/out_check are valid.
// - out_ready  in   1       downstream accepts the word.
// - out_data   out  32      data word, possibly fault-injected.
// - out_check  out  8       c[k] drives corrector input N(129+k).
// - words_cnt  out  CNT_W   count of completed output handshakes; wraps.
// BEHAVIOUR
// - Reset (async, rst_n=0): s1_valid=0, s2_valid=0, out_valid=0, out_data=0, out_check=0,
//   words_cnt=0. in_ready is 1 from the first cycle after rst_n rises.
//   Words in flight are discarded on reset; nothing partial is emitted.
// - Check equations (XOR reductions):
//   c0 = ^d[23:16] ^ d0^d4^d8^d12
//   c1 = ^d[31:24] ^ d1^d5^d9^d13
//   c2 = ^d[19:16] ^ ^d[27:24] ^ d2^d6^d10^d14
//   c3 = ^d[23:20] ^ ^d[31:28] ^ d3^d7^d11^d15
//   c4 = ^d[7:0]   ^ d16^d20^d24^d28
//   c5 = ^d[15:8]  ^ d17^d21^d25^d29
//   c6 = ^d[3:0]   ^ ^d[11:8] ^ d18^d22^d26^d30
//   c7 = ^d[7:4]   ^ ^d[15:12] ^ d19^d23^d27^d31
// - Stage 1, on in_valid&&in_ready, registers:
//   data; the 8 nibble parities ^d[4n+3:4n], n=0..7; the 8 column parities
//   (d[j]^d[j+4]^d[j+8]^d[j+12] and d[16+j]^d[20+j]^d[24+j]^d[28+j], j=0..3);
//   chk_en; inj_en; inj_pos.
// - Stage 2 combines the registered partials into c[7:0], applies chk_en, then applies
//   injection. Injection is on the final codeword, so inj_pos 32..39 flips the check bit
//   even when chk_en=0.
// - Latency: a word accepted in cycle N is presented at out_valid in cycle N+2
//   when not stalled. Throughput is 1 word/cycle.
// - Flow control:
//   s2_adv   = !s2_valid || out_ready
//   s1_adv   = !s1_valid || s2_adv
//   in_ready = s1_adv (combinational, no registered bubble)
// - Output stability: while out_valid && !out_ready, out_data and out_check hold stable.
//   out_valid never drops without a handshake.
// - Simultaneous accept and emit in the same cycle: both stages shift; no word is lost
//   or duplicated.
// - in_valid=0: a stage1 bubble propagates; out_valid falls after the last word drains.
// - words_cnt increments by 1 on each out_valid && out_ready. It wraps from 2^CNT_W-1 to 0
//   with no flag.
// - Out-of-range inj_pos (40..63): no bit flips, even with inj_en=1.
// TESTING
// - in_data=32'h00000000, chk_en=1, out_ready=1 -> out_check=8'h00 two cycles after accept.
// - in_data=32'h00000001 -> out_check=8'h51.
// - in_data=32'h80000000 -> out_check=8'h8A.
// - in_data=32'h00010000 -> out_check=8'h15.
// - in_data=32'hFFFFFFFF -> out_check=8'h00.
// - Stream of 8 words with out_ready toggling 1,0,0,1,...:
//   -> in order, none dropped or duplicated, outputs stable during stalls, words_cnt=8.
// - in_data=32'h00000001, inj_en=1, inj_pos=0 -> out_data=0, out_check=8'h51.
//   Same word with inj_pos=36 -> out_check=8'h41. inj_pos=45 -> unmodified.
// - chk_en=0, in_data=32'h80000000 -> out_check=8'h00.
// - rst_n pulsed low with 2 words in flight -> out_valid=0 immediately; neither word
//   appears afterwards; words_cnt=0.
// - Preload words_cnt to 16'hFFFF, complete one handshake -> words_cnt=16'h0000.

Source files
------------

// File: rtl/ecc_sec_check_encoder.sv
// Check-bit encoder feeding the 32-bit SEC corrector: 2-stage valid/ready pipeline
// with single-bit fault injection and a completed-handshake counter.
module ecc_sec_check_encoder #(
    parameter int DATA_W = 32,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic              chk_en,
    input  logic              inj_en,
    input  logic [5:0]        inj_pos,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [7:0]        out_check,
    output logic [CNT_W-1:0]  words_cnt
);

    generate
        if (DATA_W != 32) begin : g_bad_width
            $error("ecc_sec_check_encoder: DATA_W must be 32");
        end
    endgenerate

    logic              r_s1_valid;
    logic [DATA_W-1:0] r_s1_data;
    logic [7:0]        r_s1_nib;
    logic [7:0]        r_s1_col;
    logic              r_s1_chk_en;
    logic              r_s1_inj_en;
    logic [5:0]        r_s1_pos;

    logic              r_s2_valid;
    logic [DATA_W-1:0] r_s2_data;
    logic [7:0]        r_s2_check;
    logic [CNT_W-1:0]  r_cnt;

    logic              w_s1_adv;
    logic              w_s2_adv;
    logic              w_accept;
    logic [7:0]        w_nib;
    logic [7:0]        w_col;
    logic [7:0]        w_chk;
    logic [7:0]        w_chk_gated;
    logic [DATA_W-1:0] w_flip_d;
    logic [7:0]        w_flip_c;

    assign w_s2_adv = !r_s2_valid || out_ready;
    assign w_s1_adv = !r_s1_valid || w_s2_adv;
    assign in_ready = w_s1_adv;
    assign w_accept = in_valid && w_s1_adv;

    // Stage 1 partials: nibble parities and 4-way column parities per half-word
    always_comb begin
        w_nib = '0;
        w_col = '0;
        for (int n = 0; n < 8; n++) begin
            w_nib[n] = ^in_data[4*n +: 4];
        end
        for (int j = 0; j < 4; j++) begin
            w_col[j]   = in_data[j] ^ in_data[j+4] ^ in_data[j+8] ^ in_data[j+12];
            w_col[4+j] = in_data[16+j] ^ in_data[20+j] ^ in_data[24+j] ^ in_data[28+j];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1_valid  <= 1'b0;
            r_s1_data   <= '0;
            r_s1_nib    <= '0;
            r_s1_col    <= '0;
            r_s1_chk_en <= 1'b0;
            r_s1_inj_en <= 1'b0;
            r_s1_pos    <= '0;
        end else if (w_s1_adv) begin
            r_s1_valid <= in_valid;
            if (w_accept) begin
                r_s1_data   <= in_data;
                r_s1_nib    <= w_nib;
                r_s1_col    <= w_col;
                r_s1_chk_en <= chk_en;
                r_s1_inj_en <= inj_en;
                r_s1_pos    <= inj_pos;
            end
        end
    end

    always_comb begin
        w_chk[0] = r_s1_nib[4] ^ r_s1_nib[5] ^ r_s1_col[0];
        w_chk[1] = r_s1_nib[6] ^ r_s1_nib[7] ^ r_s1_col[1];
        w_chk[2] = r_s1_nib[4] ^ r_s1_nib[6] ^ r_s1_col[2];
        w_chk[3] = r_s1_nib[5] ^ r_s1_nib[7] ^ r_s1_col[3];
        w_chk[4] = r_s1_nib[0] ^ r_s1_nib[1] ^ r_s1_col[4];
        w_chk[5] = r_s1_nib[2] ^ r_s1_nib[3] ^ r_s1_col[5];
        w_chk[6] = r_s1_nib[0] ^ r_s1_nib[2] ^ r_s1_col[6];
        w_chk[7] = r_s1_nib[1] ^ r_s1_nib[3] ^ r_s1_col[7];
    end

    assign w_chk_gated = r_s1_chk_en ? w_chk : 8'h00;

    // Injection acts on the final codeword: 0..31 data, 32..39 check, above none
    always_comb begin
        w_flip_d = '0;
        w_flip_c = '0;
        if (r_s1_inj_en && !r_s1_pos[5]) begin
            w_flip_d = {{(DATA_W-1){1'b0}}, 1'b1} << r_s1_pos[4:0];
        end
        if (r_s1_inj_en && (r_s1_pos[5:3] == 3'b100)) begin
            w_flip_c = 8'h01 << r_s1_pos[2:0];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s2_valid <= 1'b0;
            r_s2_data  <= '0;
            r_s2_check <= '0;
        end else if (w_s2_adv) begin
            r_s2_valid <= r_s1_valid;
            if (r_s1_valid) begin
                r_s2_data  <= r_s1_data ^ w_flip_d;
                r_s2_check <= w_chk_gated ^ w_flip_c;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (r_s2_valid && out_ready) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign out_valid = r_s2_valid;
    assign out_data  = r_s2_data;
    assign out_check = r_s2_check;
    assign words_cnt = r_cnt;

endmodule

// File: tb/tb_ecc_sec_check_encoder.sv
// Bench for ecc_sec_check_encoder: directed codewords, random streams with
// backpressure against a mask-based codeword model, reset flush and counter wrap.
module tb_ecc_sec_check_encoder;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_data;
    logic        chk_en;
    logic        inj_en;
    logic [5:0]  inj_pos;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic [7:0]  out_check;
    logic [15:0] words_cnt;

    ecc_sec_check_encoder #(.DATA_W(32), .CNT_W(16)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .chk_en    (chk_en),
        .inj_en    (inj_en),
        .inj_pos   (inj_pos),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_check (out_check),
        .words_cnt (words_cnt)
    );

    always #5 clk = ~clk;

    int          n_vec = 0;
    int          n_err = 0;
    int          cyc = 0;
    int          rmode = 0;
    logic [3:0]  pat = 4'b1001;
    logic [39:0] q[$];
    logic [15:0] exp_cnt = '0;
    bit          prev_stall = 1'b0;
    logic [39:0] prev_cw;

    function automatic logic [31:0] mask(int k);
        case (k)
            0: return 32'h00FF1111;
            1: return 32'hFF002222;
            2: return 32'h0F0F4444;
            3: return 32'hF0F08888;
            4: return 32'h111100FF;
            5: return 32'h2222FF00;
            6: return 32'h44440F0F;
            default: return 32'h8888F0F0;
        endcase
    endfunction

    // Codeword {check, data}; injected bit index is inj_pos itself
    function automatic logic [39:0] ref_cw(logic [31:0] d, logic ce, logic ie, logic [5:0] pos);
        logic [7:0]  c;
        logic [39:0] cw;
        for (int k = 0; k < 8; k++) c[k] = ^(d & mask(k));
        if (!ce) c = 8'h00;
        cw = {c, d};
        if (ie && pos < 6'd40) cw[pos] = ~cw[pos];
        return cw;
    endfunction

    task automatic chk(string tag, logic [63:0] got, logic [63:0] exp);
        n_vec++;
        assert (got === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic monitor();
        if (!rst_n) begin
            q.delete();
            exp_cnt = '0;
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                chk("hold_valid", out_valid, 1);
                chk("hold_codeword", {out_check, out_data}, prev_cw);
            end
            chk("words_cnt", words_cnt, exp_cnt);
            if (out_valid && out_ready) begin
                chk("out_expected", q.size() != 0, 1);
                if (q.size() != 0) chk("stream_codeword", {out_check, out_data}, q.pop_front());
                exp_cnt = exp_cnt + 16'd1;
            end
            if (in_valid && in_ready) q.push_back(ref_cw(in_data, chk_en, inj_en, inj_pos));
            prev_stall = out_valid && !out_ready;
            prev_cw = {out_check, out_data};
        end
    endtask

    task automatic tick(output bit acc);
        @(negedge clk);
        acc = in_valid && in_ready && rst_n;
        monitor();
        @(posedge clk);
        #1;
        cyc++;
        if (rmode == 1) out_ready = pat[cyc % 4];
        if (rmode == 2) out_ready = 1'($urandom_range(0, 1));
    endtask

    task automatic tick0();
        bit b;
        tick(b);
    endtask

    task automatic push_word(logic [31:0] d, logic ce, logic ie, logic [5:0] pos);
        bit a;
        a = 1'b0;
        in_data = d; chk_en = ce; inj_en = ie; inj_pos = pos; in_valid = 1'b1;
        for (int t = 0; t < 200; t++) begin
            tick(a);
            if (a) break;
        end
        if (!a) chk("accept_timeout", a, 1);
    endtask

    task automatic drain();
        for (int t = 0; t < 100; t++) begin
            if (q.size() == 0 && !out_valid) break;
            tick0();
        end
        chk("drain", (q.size() == 0) && !out_valid, 1);
    endtask

    task automatic send_one(string tag, logic [31:0] d, logic ce, logic ie, logic [5:0] pos,
                            logic [31:0] ed, logic [7:0] ec);
        bit a;
        in_data = d; chk_en = ce; inj_en = ie; inj_pos = pos; in_valid = 1'b1;
        tick(a);
        chk({tag, "_acc"}, a, 1);
        in_valid = 1'b0;
        tick(a);
        @(negedge clk);
        chk({tag, "_valid"}, out_valid, 1);
        chk({tag, "_data"}, out_data, ed);
        chk({tag, "_check"}, out_check, ec);
        monitor();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; in_data = '0; chk_en = 1'b1;
        inj_en = 1'b0; inj_pos = '0; out_ready = 1'b0;
        repeat (3) tick0();
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_out_check", out_check, 0);
        chk("rst_words_cnt", words_cnt, 0);
        rst_n = 1'b1;
        tick0();
        chk("rst_in_ready", in_ready, 1);

        // 8-word stream with out_ready cycling 1,0,0,1
        rmode = 1;
        for (int i = 0; i < 8; i++) push_word($urandom, 1'b1, 1'b0, 6'd0);
        in_valid = 1'b0;
        drain();
        chk("stream8_cnt", words_cnt, 16'd8);
        rmode = 0;
        out_ready = 1'b1;
        tick0();

        send_one("zero", 32'h00000000, 1, 0, 6'd0, 32'h00000000, 8'h00);
        send_one("d0", 32'h00000001, 1, 0, 6'd0, 32'h00000001, 8'h51);
        send_one("d31", 32'h80000000, 1, 0, 6'd0, 32'h80000000, 8'h8A);
        send_one("d16", 32'h00010000, 1, 0, 6'd0, 32'h00010000, 8'h15);
        send_one("ones", 32'hFFFFFFFF, 1, 0, 6'd0, 32'hFFFFFFFF, 8'h00);
        send_one("inj0", 32'h00000001, 1, 1, 6'd0, 32'h00000000, 8'h51);
        send_one("inj31", 32'h00000001, 1, 1, 6'd31, 32'h80000001, 8'h51);
        send_one("inj36", 32'h00000001, 1, 1, 6'd36, 32'h00000001, 8'h41);
        send_one("inj39", 32'h00000001, 1, 1, 6'd39, 32'h00000001, 8'hD1);
        send_one("inj40", 32'h00000001, 1, 1, 6'd40, 32'h00000001, 8'h51);
        send_one("inj45", 32'h00000001, 1, 1, 6'd45, 32'h00000001, 8'h51);
        send_one("chkoff", 32'h80000000, 0, 0, 6'd0, 32'h80000000, 8'h00);
        send_one("chkoff_inj33", 32'h80000000, 0, 1, 6'd33, 32'h80000000, 8'h02);

        // Random stream: random data, injection, gaps and backpressure
        rmode = 2;
        for (int i = 0; i < 400; i++) begin
            push_word($urandom, 1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
                      6'($urandom_range(0, 63)));
            if ($urandom_range(0, 4) == 0) begin
                in_valid = 1'b0;
                tick0();
            end
        end
        in_valid = 1'b0;
        rmode = 0;
        out_ready = 1'b1;
        drain();

        // Reset with two words in flight
        out_ready = 1'b0;
        push_word(32'h12345678, 1, 0, 6'd0);
        push_word(32'h9ABCDEF0, 1, 0, 6'd0);
        in_valid = 1'b0;
        tick0();
        chk("flight_valid", out_valid, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_valid", out_valid, 0);
        chk("async_rst_cnt", words_cnt, 0);
        @(negedge clk);
        monitor();
        @(posedge clk);
        #1 rst_n = 1'b1;
        chk("post_rst_ready", in_ready, 1);
        out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick0();
            chk("post_rst_no_out", out_valid, 0);
        end

        // Counter wrap: 65535 handshakes, then one more
        for (int i = 0; i < 65535; i++) push_word($urandom, 1, 0, 6'd0);
        in_valid = 1'b0;
        drain();
        chk("cnt_ffff", words_cnt, 16'hFFFF);
        send_one("wrap", 32'h00000001, 1, 0, 6'd0, 32'h00000001, 8'h51);
        chk("cnt_wrap", words_cnt, 16'h0000);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
